// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers, each giving a one-cycle tick and a 50% square wave.
// Defining CLK_DIV_BANK_SYNC_EN adds in_sync, which realigns every channel on a single edge.
module clk_div_bank #(
    parameter int unsigned      WIDTH       = 20,
    parameter int unsigned      CHANNELS    = 4,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(20'h7FFFF)
) (
    input  logic                in_clk,
    input  logic                in_rst_n,
`ifdef CLK_DIV_BANK_SYNC_EN
    input  logic                in_sync,
`endif
    input  logic [CHANNELS-1:0] in_en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [3:0]          cfg_chan,
    input  logic [WIDTH-1:0]    cfg_div,
    output logic [CHANNELS-1:0] out_tick,
    output logic [CHANNELS-1:0] out_clk
);

    logic [CHANNELS-1:0] pending;
    logic [15:0]         pending_ext;
    logic                xfer;
    logic                sync_clear;

    // Indices past the last channel see a zero pending bit, so such writes are accepted and dropped.
    assign pending_ext = 16'(pending);
    assign cfg_ready   = !pending_ext[cfg_chan];
    assign xfer        = cfg_valid && cfg_ready;

`ifdef CLK_DIV_BANK_SYNC_EN
    assign sync_clear = in_sync;
`else
    assign sync_clear = 1'b0;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] div;
        logic [WIDTH-1:0] shadow;
        logic             pend;
        logic             tick;
        logic             sq;
        logic             hit;
        logic             wrap;

        assign hit  = xfer && (cfg_chan == 4'(i));
        assign wrap = cnt >= div;

        // A new divisor only lands when cnt is back at zero, so the square wave never glitches.
        always_ff @(posedge in_clk or negedge in_rst_n) begin
            if (!in_rst_n) begin
                cnt    <= '0;
                div    <= DEFAULT_DIV;
                shadow <= DEFAULT_DIV;
                pend   <= 1'b0;
                tick   <= 1'b0;
                sq     <= 1'b0;
            end else begin
                if (hit) begin
                    shadow <= cfg_div;
                end
                if (sync_clear || !in_en[i]) begin
                    cnt  <= '0;
                    tick <= 1'b0;
                    sq   <= 1'b0;
                    if (pend) begin
                        div <= shadow;
                    end
                    pend <= hit;
                end else if (wrap) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                    sq   <= ~sq;
                    if (pend) begin
                        div <= shadow;
                    end
                    pend <= hit;
                end else begin
                    cnt  <= cnt + 1'b1;
                    tick <= 1'b0;
                    if (hit) begin
                        pend <= 1'b1;
                    end
                end
            end
        end

        assign pending[i]  = pend;
        assign out_tick[i] = tick;
        assign out_clk[i]  = sq;
    end

endmodule
